// File: rtl/lsu_ctrl_if.sv
// Bundle of the request, response and data-memory signals around lsu_ctrl.
// The slave modport is the controller's view; the master modport is the pipeline and memory side.
interface lsu_ctrl_if;
  // Handshake rule: on both the request and response channels, a transfer occurs on a rising
  // edge where valid && ready. While valid is high and ready is low, the producer holds the
  // payload unchanged. Ready never depends on valid.
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;

  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [1:0]  resp_fault_o;

  logic        mem_re_o;
  logic        mem_we_o;
  logic [31:0] mem_r_addr_o;
  logic [31:0] mem_w_addr_o;
  logic [31:0] mem_w_data_o;
  logic [2:0]  mem_mode_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  resp_ready_i, mem_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
    output mem_re_o, mem_we_o, mem_r_addr_o, mem_w_addr_o, mem_w_data_o, mem_mode_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output resp_ready_i, mem_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o,
    input  mem_re_o, mem_we_o, mem_r_addr_o, mem_w_addr_o, mem_w_data_o, mem_mode_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control: validates one request at a time, drives the memory port for a single
// ACCESS cycle, then holds a registered extended load result or store acknowledgement.
module lsu_ctrl #(
    parameter logic [31:0] MEM_BASE         = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE         = 32'h0010_0000,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    lsu_ctrl_if.slave  bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;
    localparam logic [1:0] FAULT_F3    = 2'b11;

    localparam logic [32:0] RANGE_LO = {1'b0, MEM_BASE};
    localparam logic [32:0] RANGE_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 33'd1;

    state_t      state;
    logic        req_ready_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  fault_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [2:0]  mem_mode_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  resp_fault_q;

    logic        f3_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  last_off;
    logic [32:0] addr_lo;
    logic [32:0] addr_hi;
    logic [1:0]  req_fault;
    logic [31:0] load_ext;
    logic        handshake;

    assign handshake = bus.req_valid_i && (state == IDLE);

    // Request checks, evaluated on the raw request so the fault is registered with it.
    always_comb begin
        f3_illegal = 1'b1;
        case (bus.req_funct3_i)
            3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
            3'b100, 3'b101:         f3_illegal = bus.req_we_i;
            default:                f3_illegal = 1'b1;
        endcase

        last_off = 2'd3;
        case (bus.req_funct3_i[1:0])
            2'b00:   last_off = 2'd0;
            2'b01:   last_off = 2'd1;
            default: last_off = 2'd3;
        endcase

        misaligned = 1'b0;
        if (!ALLOW_MISALIGNED) begin
            misaligned = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                         ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
        end

        // 33-bit compare so an access straddling 32'hFFFF_FFFF cannot wrap into range.
        addr_lo      = {1'b0, bus.req_addr_i};
        addr_hi      = addr_lo + {31'd0, last_off};
        out_of_range = (addr_lo < RANGE_LO) || (addr_hi > RANGE_HI);

        if (f3_illegal)        req_fault = FAULT_F3;
        else if (misaligned)   req_fault = FAULT_ALIGN;
        else if (out_of_range) req_fault = FAULT_RANGE;
        else                   req_fault = FAULT_OK;
    end

    // Memory returns bytes starting at the access address, so no lane shifting is needed.
    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{bus.mem_data_i[7]}}, bus.mem_data_i[7:0]};
            3'b001:  load_ext = {{16{bus.mem_data_i[15]}}, bus.mem_data_i[15:0]};
            3'b100:  load_ext = {24'd0, bus.mem_data_i[7:0]};
            3'b101:  load_ext = {16'd0, bus.mem_data_i[15:0]};
            default: load_ext = bus.mem_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            fault_q      <= FAULT_OK;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_mode_q   <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= FAULT_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        we_q        <= bus.req_we_i;
                        funct3_q    <= bus.req_funct3_i;
                        fault_q     <= req_fault;
                        mem_re_q    <= (req_fault == FAULT_OK) && !bus.req_we_i;
                        mem_we_q    <= (req_fault == FAULT_OK) && bus.req_we_i;
                        mem_addr_q  <= bus.req_addr_i - MEM_BASE;
                        mem_wdata_q <= bus.req_wdata_i;
                        mem_mode_q  <= bus.req_funct3_i;
                        req_ready_q <= 1'b0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_re_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= 32'd0;
                    mem_wdata_q  <= 32'd0;
                    mem_mode_q   <= 3'd0;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= fault_q;
                    resp_rdata_q <= ((fault_q == FAULT_OK) && !we_q) ? load_ext : 32'd0;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.resp_fault_o = resp_fault_q;

    // Enables also see reset directly so a reset landing mid-ACCESS never writes memory.
    assign bus.mem_re_o     = mem_re_q && rst_n_i;
    assign bus.mem_we_o     = mem_we_q && rst_n_i;
    assign bus.mem_r_addr_o = mem_addr_q;
    assign bus.mem_w_addr_o = mem_addr_q;
    assign bus.mem_w_data_o = mem_wdata_q;
    assign bus.mem_mode_o   = mem_mode_q;

    assign dbg_state_o = state;

endmodule
